// File: rtl/tx_bit_encoder_if.sv
// Handshake/line bundle between the TX packet source, the bit timer and the encoder.
interface tx_bit_encoder_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;
  logic       shift_strobe;
  logic       enable_timer;
  logic       dp_out;
  logic       dm_out;
  logic       tx_busy;
  logic       eop_done;

  modport master (
    output tx_start, tx_data, tx_data_valid, shift_strobe,
    input  tx_data_ready, enable_timer, dp_out, dm_out, tx_busy, eop_done
  );

  modport slave (
    input  tx_start, tx_data, tx_data_valid, shift_strobe,
    output tx_data_ready, enable_timer, dp_out, dm_out, tx_busy, eop_done
  );
endinterface

// File: rtl/tx_bit_encoder.sv
// NRZI bit encoder with bit stuffing: SYNC byte, payload bytes LSB first, then SE0/J EOP.
module tx_bit_encoder #(
  parameter int unsigned STUFF_LIMIT  = 6,
  parameter int unsigned EOP_SE0_BITS = 2
) (
  input logic             clk,
  input logic             rst,
  tx_bit_encoder_if.slave bus
);

  localparam int unsigned EW = $clog2(EOP_SE0_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } state_t;

  state_t          r_state,    w_state_nx;
  logic [7:0]      r_shreg,    w_shreg_nx;
  logic [2:0]      r_bit_cnt,  w_bit_cnt_nx;
  logic [2:0]      r_ones_cnt, w_ones_cnt_nx;
  logic [EW-1:0]   r_eop_cnt,  w_eop_cnt_nx;
  logic            r_dp,       w_dp_nx;
  logic            r_dm,       w_dm_nx;
  logic            r_eop_done, w_eop_done_nx;
  logic            w_ready;
  logic            w_stuff;
  logic            w_bit;

  assign w_stuff = (r_ones_cnt == 3'(STUFF_LIMIT));
  assign w_bit   = r_shreg[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_ones_cnt <= '0;
      r_eop_cnt  <= '0;
      r_dp       <= 1'b1;
      r_dm       <= 1'b0;
      r_eop_done <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_shreg    <= w_shreg_nx;
      r_bit_cnt  <= w_bit_cnt_nx;
      r_ones_cnt <= w_ones_cnt_nx;
      r_eop_cnt  <= w_eop_cnt_nx;
      r_dp       <= w_dp_nx;
      r_dm       <= w_dm_nx;
      r_eop_done <= w_eop_done_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_shreg_nx    = r_shreg;
    w_bit_cnt_nx  = r_bit_cnt;
    w_ones_cnt_nx = r_ones_cnt;
    w_eop_cnt_nx  = r_eop_cnt;
    w_dp_nx       = r_dp;
    w_dm_nx       = r_dm;
    w_eop_done_nx = 1'b0;
    w_ready       = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_dp_nx = 1'b1;
        w_dm_nx = 1'b0;
        if (bus.tx_start) begin
          w_state_nx    = SYNC;
          w_shreg_nx    = 8'h80;
          w_bit_cnt_nx  = '0;
          w_ones_cnt_nx = '0;
          w_eop_cnt_nx  = '0;
        end
      end

      SYNC, DATA: begin
        if (bus.shift_strobe) begin
          // A stuffed 0 takes a whole bit time and leaves shreg/bit_cnt untouched.
          if (w_stuff) begin
            w_dp_nx       = ~r_dp;
            w_dm_nx       = ~r_dm;
            w_ones_cnt_nx = '0;
          end else begin
            if (!w_bit) begin
              w_dp_nx = ~r_dp;
              w_dm_nx = ~r_dm;
            end
            w_shreg_nx    = {1'b0, r_shreg[7:1]};
            w_bit_cnt_nx  = r_bit_cnt + 3'd1;
            w_ones_cnt_nx = w_bit ? r_ones_cnt + 3'd1 : 3'd0;
            if (r_bit_cnt == 3'd7) begin
              if (bus.tx_data_valid) begin
                w_ready    = 1'b1;
                w_shreg_nx = bus.tx_data;
                w_state_nx = DATA;
              end else begin
                w_state_nx   = EOP_SE0;
                w_eop_cnt_nx = '0;
              end
            end
          end
        end
      end

      EOP_SE0: begin
        if (bus.shift_strobe) begin
          if (w_stuff) begin
            w_dp_nx       = ~r_dp;
            w_dm_nx       = ~r_dm;
            w_ones_cnt_nx = '0;
          end else begin
            w_dp_nx = 1'b0;
            w_dm_nx = 1'b0;
            if (r_eop_cnt == EW'(EOP_SE0_BITS - 1)) begin
              w_state_nx   = EOP_J;
              w_eop_cnt_nx = '0;
            end else begin
              w_eop_cnt_nx = r_eop_cnt + EW'(1);
            end
          end
        end
      end

      EOP_J: begin
        if (bus.shift_strobe) begin
          if (r_eop_cnt == '0) begin
            w_dp_nx      = 1'b1;
            w_dm_nx      = 1'b0;
            w_eop_cnt_nx = EW'(1);
          end else begin
            w_state_nx    = IDLE;
            w_eop_done_nx = 1'b1;
          end
        end
      end

      default: w_state_nx = IDLE;
    endcase
  end

  assign bus.tx_data_ready = w_ready & ~rst;
  assign bus.enable_timer  = (r_state != IDLE);
  assign bus.tx_busy       = (r_state != IDLE);
  assign bus.dp_out        = r_dp;
  assign bus.dm_out        = r_dm;
  assign bus.eop_done      = r_eop_done;

endmodule

// File: tb/tb_tx_bit_encoder.sv
// Bench for tx_bit_encoder: per-packet expected line levels built from the bit-stuffed NRZI rules.
module tb_tx_bit_encoder;
  localparam int unsigned LIM  = 6;
  localparam int unsigned SE0N = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_bit_encoder_if bus();

  tx_bit_encoder #(.STUFF_LIMIT(LIM), .EOP_SE0_BITS(SE0N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] pkt[$];
  logic       e_dp[$];
  logic       e_dm[$];
  logic       e_rdy[$];
  int         e_bnd[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic dp, input logic dm, input logic rdy, input int bnd);
    e_dp.push_back(dp);
    e_dm.push_back(dm);
    e_rdy.push_back(rdy);
    e_bnd.push_back(bnd);
  endtask

  // Expected line level after each strobe of a whole packet, plus the strobe after EOP_J's J.
  task automatic build_model();
    logic       line;
    int         ones;
    int         total;
    int         c;
    logic [7:0] byt;
    logic       b;
    e_dp.delete(); e_dm.delete(); e_rdy.delete(); e_bnd.delete();
    line  = 1'b1;
    ones  = 0;
    total = 8 * (pkt.size() + 1);
    for (int i = 0; i < total; i++) begin
      c   = i / 8;
      byt = (c == 0) ? 8'h80 : pkt[c-1];
      b   = byt[i % 8];
      if (ones == LIM) begin
        line = ~line;
        push(line, ~line, 1'b0, -1);
        ones = 0;
      end
      if (!b) line = ~line;
      ones = b ? ones + 1 : 0;
      push(line, ~line, ((i % 8) == 7) && (c < pkt.size()), ((i % 8) == 7) ? c : -1);
    end
    if (ones == LIM) begin
      line = ~line;
      push(line, ~line, 1'b0, -1);
    end
    repeat (SE0N) push(1'b0, 1'b0, 1'b0, -1);
    push(1'b1, 1'b0, 1'b0, -1);
    push(1'b1, 1'b0, 1'b0, -1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_dp"}, bus.dp_out, 1);
    chk({tag, "_dm"}, bus.dm_out, 0);
    chk({tag, "_busy"}, bus.tx_busy, 0);
    chk({tag, "_tmr"}, bus.enable_timer, 0);
    chk({tag, "_eop"}, bus.eop_done, 0);
  endtask

  task automatic run_packet(input int abort_at);
    int   last;
    int   c;
    logic pdp, pdm;
    build_model();
    last = e_dp.size() - 1;
    bus.tx_start      = 1'b1;
    bus.shift_strobe  = 1'($urandom_range(0, 1));
    bus.tx_data_valid = 1'($urandom_range(0, 1));
    bus.tx_data       = 8'($urandom);
    step();
    bus.tx_start = 1'b0;
    chk("start_busy", bus.tx_busy, 1);
    chk("start_tmr", bus.enable_timer, 1);
    chk("start_dp", bus.dp_out, 1);
    chk("start_dm", bus.dm_out, 0);
    for (int s = 0; s <= last; s++) begin
      pdp = (s == 0) ? 1'b1 : e_dp[s-1];
      pdm = (s == 0) ? 1'b0 : e_dm[s-1];
      repeat ($urandom_range(0, 2)) begin
        bus.shift_strobe  = 1'b0;
        bus.tx_start      = ($urandom_range(0, 3) == 0);
        bus.tx_data_valid = 1'($urandom_range(0, 1));
        bus.tx_data       = 8'($urandom);
        #1;
        chk("gap_rdy", bus.tx_data_ready, 0);
        step();
        chk("gap_dp", bus.dp_out, pdp);
        chk("gap_dm", bus.dm_out, pdm);
        chk("gap_busy", bus.tx_busy, 1);
        chk("gap_eop", bus.eop_done, 0);
      end
      bus.shift_strobe = 1'b1;
      bus.tx_start     = ($urandom_range(0, 3) == 0);
      if (e_bnd[s] >= 0) begin
        c = e_bnd[s];
        bus.tx_data_valid = (c < pkt.size());
        bus.tx_data       = (c < pkt.size()) ? pkt[c] : 8'($urandom);
      end else begin
        bus.tx_data_valid = 1'($urandom_range(0, 1));
        bus.tx_data       = 8'($urandom);
      end
      if (s == abort_at) begin
        rst = 1'b1;
        #1;
        chk("rst_rdy", bus.tx_data_ready, 0);
        step();
        rst = 1'b0;
        bus.tx_start = 1'b0;
        check_idle("abort");
        repeat (4) begin
          bus.shift_strobe = 1'b1;
          step();
          check_idle("post_abort");
        end
        bus.shift_strobe = 1'b0;
        return;
      end
      #1;
      chk("rdy", bus.tx_data_ready, e_rdy[s]);
      step();
      bus.shift_strobe = 1'b0;
      bus.tx_start     = 1'b0;
      chk("dp", bus.dp_out, e_dp[s]);
      chk("dm", bus.dm_out, e_dm[s]);
      chk("eop", bus.eop_done, (s == last));
      chk("busy", bus.tx_busy, (s != last));
      chk("tmr", bus.enable_timer, (s != last));
    end
    bus.tx_data_valid = 1'b0;
    step();
    check_idle("after_eop");
  endtask

  initial begin
    bus.tx_start      = 1'b0;
    bus.tx_data       = 8'h00;
    bus.tx_data_valid = 1'b0;
    bus.shift_strobe  = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("reset");
    chk("reset_rdy", bus.tx_data_ready, 0);

    repeat (3) begin
      bus.shift_strobe = 1'b1;
      step();
      check_idle("idle_strobe");
    end
    bus.shift_strobe = 1'b0;

    pkt = {};
    run_packet(-1);
    pkt = '{8'hFF};
    run_packet(-1);
    pkt = '{8'hFC};
    run_packet(-1);
    pkt = '{8'hA5, 8'h5A};
    run_packet(-1);
    pkt = '{8'hFF, 8'h3C, 8'h81};
    run_packet(12);
    step();
    check_idle("abort_settle");

    for (int p = 0; p < 8; p++) begin
      pkt = {};
      repeat ($urandom_range(0, 4))
        pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      run_packet(-1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
